btb_predictor: RTL and testbench
================================

// Module: btb_predictor
// PURPOSE
//   Direct-mapped branch target buffer with 2-bit counters. Consumes branch
//   targets produced in decode (sign-extend, shift-left-2, add to PC+4) and
//   predicts the next fetch PC for the IF stage. Detects mispredictions when
//   the branch resolves and issues a registered one-cycle PC redirect.
// PARAMETERS
//   ENTRIES  16  number of BTB entries, power of two
//   IDX_W    4   log2(ENTRIES); tag width = 30-IDX_W
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous reset, active-high
//   if_pc           in   32  current fetch PC (word aligned)
//   pred_taken      out  1   lookup hit with counter predicting taken
//   pred_npc        out  32  predicted next fetch PC
//   upd_valid       in   1   a branch resolves this cycle
//   upd_pc          in   32  PC of the resolving branch
//   upd_taken       in   1   actual branch outcome
//   upd_target      in   32  computed branch target
//   upd_pred_taken  in   1   pred_taken carried down the pipe with the branch
//   upd_pred_npc    in   32  pred_npc carried down the pipe with the branch
//   inv_all         in   1   invalidate all entries
//   redirect        out  1   one-cycle pulse: fetch must restart at redirect_pc
//   redirect_pc     out  32  corrected next PC
// BEHAVIOUR
//   - Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Each entry holds valid, tag,
//     target[31:2] (bits [1:0] of upd_target are dropped and read back as 00),
//     and a 2-bit saturating counter ctr.
//   - Lookup is combinational, zero latency. hit = valid & tag match.
//     pred_taken = hit & ctr[1]. pred_npc = pred_taken ? {target,2'b00} : if_pc+4.
//     if_pc+4 wraps modulo 2^32.
//   - Update on the rising edge when upd_valid=1:
//     hit: ctr increments if taken, else decrements; saturates at 11 and 00.
//       target is rewritten only when taken.
//     miss and taken: allocate (valid=1, new tag, target, ctr=10), overwriting
//       any entry at that index.
//     miss and not taken: no change.
//   - Mispredict check: actual_npc = upd_taken ? upd_target : upd_pc+4.
//     mispred = upd_valid & (upd_pred_npc != actual_npc).
//     On each edge: redirect <= mispred; redirect_pc <= mispred ? actual_npc :
//     redirect_pc (holds its value otherwise). Latency is 1 cycle.
//     redirect is never high for two consecutive cycles unless two
//     mispredicting updates arrive back to back.
//   - Same-cycle lookup and update to one index: the lookup returns the
//     pre-update contents. The new contents are visible from the next cycle.
//   - inv_all clears every valid bit at the edge and has priority over an
//     update in the same cycle (no allocation and no counter change). The
//     redirect computation is unaffected by inv_all.
//   - Reset (async, any time, including mid-update):
//     all valid=0, all ctr=01, redirect=0, redirect_pc=0.
//     pred_taken=0 and pred_npc=if_pc+4 while no entry is valid.
//     Tag and target storage need no reset.
// TESTING
//   1. rst=1, if_pc=0x00400000 -> pred_taken=0, pred_npc=0x00400004,
//      redirect=0 immediately, without waiting for a clock edge.
//   2. Update upd_pc=0x00400010, taken, target 0x00400040, pred_npc=0x00400014
//      -> next cycle redirect=1, redirect_pc=0x00400040. Then
//      if_pc=0x00400010 -> pred_taken=1, pred_npc=0x00400040.
//   3. Hysteresis: from ctr=10, one not-taken update -> lookup pred_taken=0 and
//      redirect_pc=0x00400014. Then 3 taken updates -> ctr=11; one not-taken
//      update -> still pred_taken=1.
//   4. Alias: entry for 0x00400010 exists; lookup 0x00400050 (same index,
//      different tag) -> miss, pred_npc=0x00400054. A taken update of
//      0x00400050 replaces the entry; 0x00400010 then misses.
//   5. Same edge: update of index 4 with lookup of index 4 -> old prediction
//      this cycle, new one next cycle. inv_all together with upd_valid -> all
//      lookups miss, redirect still pulses if mispredicted.
//   6. Assert rst between mispredict edge and next edge -> redirect drops to 0
//      asynchronously and all entries miss after release.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, zero-latency
// lookup and a registered one-cycle redirect on branch misprediction.
module btb_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_npc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_npc,
    input  logic        inv_all,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [29:0]        tgt_q [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit;
    logic [31:0]      actual_npc;
    logic             mispred;

    // Misprediction is judged on the carried next-PC alone.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    assign l_idx = if_pc[IDX_W+1:2];
    assign l_tag = if_pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];

    always_comb begin
        l_hit      = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        pred_taken = l_hit && ctr_q[l_idx][1];
        pred_npc   = pred_taken ? {tgt_q[l_idx], 2'b00} : if_pc + 32'd4;
    end

    always_comb begin
        u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        actual_npc = upd_taken ? upd_target : upd_pc + 32'd4;
        mispred    = upd_valid && (upd_pred_npc != actual_npc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken && ctr_q[u_idx] != 2'b11) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
                end else if (!upd_taken && ctr_q[u_idx] != 2'b00) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= 2'b10;
            end
        end
    end

    // Tag rewrite on a taken hit is a no-op; on a taken miss it allocates.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken && !inv_all) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= upd_target[31:2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= mispred;
            if (mispred) begin
                redirect_pc <= actual_npc;
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: per-cycle comparison against a table model
// plus literal expectations for the reset, allocate, hysteresis and alias cases.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_npc;
    logic        inv_all;
    logic        redirect;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    btb_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_npc       (pred_npc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_npc   (upd_pred_npc),
        .inv_all        (inv_all),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Model: table of 16 entries addressed by word number modulo 16.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    bit          m_redir;
    logic [31:0] m_rpc;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % 16;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> 6;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_redir = 1'b0;
            m_rpc   = 32'h0;
        end else begin
            logic [31:0] actual;
            bit          mis;
            int unsigned k;
            actual  = upd_taken ? upd_target : upd_pc + 32'd4;
            mis     = upd_valid && (upd_pred_npc != actual);
            k       = idx_of(upd_pc);
            if (inv_all) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            end else if (upd_valid) begin
                if (m_hit(upd_pc)) begin
                    if (upd_taken) begin
                        m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                        m_tgt[k] = upd_target & 32'hFFFF_FFFC;
                    end else begin
                        m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[k] = 1'b1;
                    m_tag[k]   = tag_of(upd_pc);
                    m_tgt[k]   = upd_target & 32'hFFFF_FFFC;
                    m_ctr[k]   = 2;
                end
            end
            m_redir = mis;
            if (mis) m_rpc = actual;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit          e_tk;
        logic [31:0] e_npc;
        e_tk  = m_hit(if_pc) && m_ctr[idx_of(if_pc)] >= 2;
        e_npc = e_tk ? m_tgt[idx_of(if_pc)] : if_pc + 32'd4;
        check("model pred_taken", {31'b0, pred_taken}, {31'b0, e_tk});
        check("model pred_npc", pred_npc, e_npc);
        check("model redirect", {31'b0, redirect}, {31'b0, m_redir});
        check("model redirect_pc", redirect_pc, m_rpc);
    end

    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic [31:0] pnpc);
        upd_valid    = 1'b1;
        upd_pc       = pc;
        upd_taken    = tk;
        upd_target   = tgt;
        upd_pred_npc = pnpc;
        @(posedge clk);
        #2;
        upd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_pc = 32'h0040_0000; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_npc = '0; inv_all = 1'b0;
        #1;
        check("reset pred_taken", {31'b0, pred_taken}, 32'd0);
        check("reset pred_npc", pred_npc, 32'h0040_0004);
        check("reset redirect", {31'b0, redirect}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Allocate 0x00400010 -> 0x00400040 with a mispredicted fall-through.
        do_upd(32'h0040_0010, 1'b1, 32'h0040_0040, 32'h0040_0014);
        if_pc = 32'h0040_0010;
        #1;
        check("alloc redirect", {31'b0, redirect}, 32'd1);
        check("alloc redirect_pc", redirect_pc, 32'h0040_0040);
        check("alloc pred_taken", {31'b0, pred_taken}, 32'd1);
        check("alloc pred_npc", pred_npc, 32'h0040_0040);

        // Hysteresis: 10 -> 01 drops prediction; saturate at 11, one not-taken keeps it.
        do_upd(32'h0040_0010, 1'b0, 32'h0040_0040, 32'h0040_0040);
        #1;
        check("hyst drop pred_taken", {31'b0, pred_taken}, 32'd0);
        check("hyst redirect_pc", redirect_pc, 32'h0040_0014);
        repeat (3) do_upd(32'h0040_0010, 1'b1, 32'h0040_0040, 32'h0040_0040);
        do_upd(32'h0040_0010, 1'b0, 32'h0040_0040, 32'h0040_0040);
        #1;
        check("hyst hold pred_taken", {31'b0, pred_taken}, 32'd1);
        check("hyst hold pred_npc", pred_npc, 32'h0040_0040);

        // Alias at index 4 with a different tag.
        if_pc = 32'h0040_0050;
        #1;
        check("alias miss pred_taken", {31'b0, pred_taken}, 32'd0);
        check("alias miss pred_npc", pred_npc, 32'h0040_0054);
        do_upd(32'h0040_0050, 1'b1, 32'h0040_0103, 32'h0040_0054);
        #1;
        check("alias new pred_npc", pred_npc, 32'h0040_0100);
        if_pc = 32'h0040_0010;
        #1;
        check("alias old evicted", pred_npc, 32'h0040_0014);

        // Same-edge lookup and update: old prediction now, new one after the edge.
        if_pc = 32'h0040_0050;
        upd_valid = 1'b1; upd_pc = 32'h0040_0050; upd_taken = 1'b0;
        upd_pred_npc = 32'h0040_0100;
        #1;
        check("same-edge old pred_npc", pred_npc, 32'h0040_0100);
        @(posedge clk);
        #2 upd_valid = 1'b0;
        #1;
        check("same-edge new pred_npc", pred_npc, 32'h0040_0054);

        // inv_all beats allocation but the redirect still fires.
        inv_all = 1'b1;
        do_upd(32'h0040_0090, 1'b1, 32'h0040_0200, 32'h0040_0094);
        inv_all = 1'b0;
        if_pc = 32'h0040_0090;
        #1;
        check("inv redirect", {31'b0, redirect}, 32'd1);
        check("inv redirect_pc", redirect_pc, 32'h0040_0200);
        check("inv no alloc", pred_npc, 32'h0040_0094);
        if_pc = 32'h0040_0050;
        #1;
        check("inv old miss", {31'b0, pred_taken}, 32'd0);

        // Async reset between the mispredict edge and the following edge.
        do_upd(32'h0040_0020, 1'b1, 32'h0040_0080, 32'h0040_0024);
        if_pc = 32'h0040_0020;
        #1;
        check("pre-rst redirect", {31'b0, redirect}, 32'd1);
        check("pre-rst pred_taken", {31'b0, pred_taken}, 32'd1);
        rst = 1'b1;
        #1;
        check("async rst redirect", {31'b0, redirect}, 32'd0);
        check("async rst redirect_pc", redirect_pc, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("post-rst miss", pred_npc, 32'h0040_0024);
        repeat (2) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
